mips_control_fsm: RTL and testbench

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

---
 rtl/mips_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_mips_control_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: IDLE -> DECODE -> EXEC -> MEM -> WB sequencing with
// per-state datapath strobes, done/illegal pulses and a retired-instruction counter.
module mips_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             zero,
  output logic [3:0]       AluAddress,
  output logic             ALUSrcB,
  output logic             RegDst,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;
  typedef enum logic [3:0] {
    OpIll, OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpLw, OpSw, OpAddi, OpBeq, OpJ
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d, dec_op;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Only opcode and funct drive control; register fields belong to the datapath.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr_q[25:6];

  function automatic op_e decode_op(input logic [5:0] opc, input logic [5:0] fn);
    op_e op;
    op = OpIll;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000: op = OpAdd;
          6'b100010: op = OpSub;
          6'b100100: op = OpAnd;
          6'b100101: op = OpOr;
          6'b101010: op = OpSlt;
          default:   op = OpIll;
        endcase
      end
      6'b100011: op = OpLw;
      6'b101011: op = OpSw;
      6'b001000: op = OpAddi;
      6'b000100: op = OpBeq;
      6'b000010: op = OpJ;
      default:   op = OpIll;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] alu_sel(input op_e op);
    logic [3:0] sel;
    case (op)
      OpAdd, OpLw, OpSw, OpAddi: sel = 4'b0001;
      OpSub:                     sel = 4'b0011;
      OpAnd:                     sel = 4'b0100;
      OpOr:                      sel = 4'b1000;
      OpSlt:                     sel = 4'b1100;
      OpBeq:                     sel = 4'b1011;
      OpJ:                       sel = 4'b1111;
      default:                   sel = 4'b0000;
    endcase
    return sel;
  endfunction

  assign dec_op = decode_op(instr_q[31:26], instr_q[5:0]);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = Instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        op_d    = dec_op;
        state_d = (dec_op == OpIll) ? StIdle : StExec;
      end
      StExec: begin
        case (op_q)
          OpLw, OpSw:  state_d = StMem;
          OpBeq, OpJ:  state_d = StIdle;
          default:     state_d = StWb;
        endcase
      end
      StMem:   state_d = (op_q == OpLw) ? StWb : StIdle;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (done) retired_d = retired_q + 1'b1;
  end

  always_comb begin
    instr_ready = rst_n && (state_q == StIdle);
    AluAddress  = 4'b0000;
    ALUSrcB     = 1'b0;
    RegDst      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'b00;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StDecode: illegal = (dec_op == OpIll);
      StExec: begin
        AluAddress = alu_sel(op_q);
        ALUSrcB    = (op_q == OpLw) || (op_q == OpSw) || (op_q == OpAddi);
        if (op_q == OpBeq) begin
          PCWrite = zero;
          PCSrc   = 2'b01;
          done    = 1'b1;
        end else if (op_q == OpJ) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
          done    = 1'b1;
        end
      end
      StMem: begin
        // ALU still presents the effective address while memory is accessed.
        AluAddress = alu_sel(op_q);
        ALUSrcB    = 1'b1;
        MemRead    = (op_q == OpLw);
        MemWrite   = (op_q == OpSw);
        done       = (op_q == OpSw);
      end
      StWb: begin
        RegWrite = 1'b1;
        RegDst   = (op_q != OpLw) && (op_q != OpAddi);
        MemToReg = (op_q == OpLw);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpIll;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench: per-cycle expected control vectors are queued at issue and
// popped/compared on each falling edge while the instruction runs.
module tb_mips_control_fsm;

  localparam int unsigned CntW = 4;
  localparam int KR = 0, KAddi = 1, KLw = 2, KSw = 3, KBeq = 4, KJ = 5, KIll = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr = 32'h0;
  logic            instr_valid = 1'b0;
  logic            zero = 1'b0;
  logic            instr_ready;
  logic [3:0]      alu_address;
  logic            alu_src_b, reg_dst, mem_read, mem_write, mem_to_reg, reg_write, pc_write;
  logic [1:0]      pc_src;
  logic            done, illegal;
  logic [CntW-1:0] retired;

  mips_control_fsm #(.CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .AluAddress(alu_address), .ALUSrcB(alu_src_b),
    .RegDst(reg_dst), .MemRead(mem_read), .MemWrite(mem_write), .MemToReg(mem_to_reg),
    .RegWrite(reg_write), .PCWrite(pc_write), .PCSrc(pc_src), .done(done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {instr_ready, alu_address, alu_src_b, reg_dst, mem_read, mem_write, mem_to_reg,
                reg_write, pc_write, pc_src, done, illegal};

  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t            sb[$];
  int              n_tests = 0;
  int              n_fail = 0;
  logic [CntW-1:0] exp_ret = '0;

  function automatic logic [15:0] mk(input logic rdy, input logic [3:0] alu, input logic srcb,
                                     input logic rdst, input logic mr, input logic mw,
                                     input logic m2r, input logic rw, input logic pcw,
                                     input logic [1:0] pcs, input logic dn, input logic ill);
    return {rdy, alu, srcb, rdst, mr, mw, m2r, rw, pcw, pcs, dn, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_seq(input string tag, input int kind, input logic [3:0] alu,
                          input logic z);
    if (kind == KIll) begin
      push({tag, ".dec"}, mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
      return;
    end
    push({tag, ".dec"}, mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    case (kind)
      KR: begin
        push({tag, ".exe"}, mk(0, alu, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        push({tag, ".wb"},  mk(0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 1, 0));
      end
      KAddi: begin
        push({tag, ".exe"}, mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        push({tag, ".wb"},  mk(0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0));
      end
      KLw: begin
        push({tag, ".exe"}, mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        push({tag, ".mem"}, mk(0, 4'b0001, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        push({tag, ".wb"},  mk(0, 4'h0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0));
      end
      KSw: begin
        push({tag, ".exe"}, mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        push({tag, ".mem"}, mk(0, 4'b0001, 1, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0));
      end
      KBeq: push({tag, ".exe"}, mk(0, 4'b1011, 0, 0, 0, 0, 0, 0, z, 2'b01, 1, 0));
      KJ:   push({tag, ".exe"}, mk(0, 4'b1111, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0));
      default: ;
    endcase
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      check(e.tag, {16'h0, obs}, {16'h0, e.v});
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic z, input int kind,
                       input logic [3:0] alu);
    @(negedge clk);
    check({tag, ".idle"}, {16'h0, obs}, {16'h0, mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    check({tag, ".ret"}, {28'h0, retired}, {28'h0, exp_ret});
    instr       = ins;
    instr_valid = 1'b1;
    zero        = z;
    push_seq(tag, kind, alu, z);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0800_0010;  // a j word that must not be captured outside IDLE
    drain(8);
    if (kind != KIll) exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst.out", {16'h0, obs}, 32'h0);
    check("rst.ret", {28'h0, retired}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add",  32'h0022_1820, 1'b0, KR,    4'b0001);
    issue("sub",  32'h0022_1822, 1'b0, KR,    4'b0011);
    issue("and",  32'h0022_1824, 1'b0, KR,    4'b0100);
    issue("or",   32'h0022_1825, 1'b0, KR,    4'b1000);
    issue("slt",  32'h0022_182A, 1'b0, KR,    4'b1100);
    issue("addi", 32'h2022_0005, 1'b0, KAddi, 4'b0001);
    issue("lw",   32'h8C22_0004, 1'b0, KLw,   4'b0001);
    issue("sw",   32'hAC22_0004, 1'b0, KSw,   4'b0001);
    issue("beqT", 32'h1022_0003, 1'b1, KBeq,  4'b1011);
    issue("beqN", 32'h1022_0003, 1'b0, KBeq,  4'b1011);
    issue("j",    32'h0800_0010, 1'b0, KJ,    4'b1111);
    issue("ill",  32'h0022_183F, 1'b0, KIll,  4'b0000);
    issue("illop", 32'hFC00_0000, 1'b0, KIll, 4'b0000);

    // Reset asserted while a lw sits in MEM.
    @(negedge clk);
    check("rstmid.ret0", {28'h0, retired}, {28'h0, exp_ret});
    instr       = 32'h8C22_0004;
    instr_valid = 1'b1;
    push_seq("rstmid", KLw, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    drain(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.out", {16'h0, obs}, 32'h0);
    check("rstmid.ret", {28'h0, retired}, 32'h0);
    sb.delete();
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid.ready", {16'h0, obs},
          {16'h0, mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    issue("add2", 32'h0022_1820, 1'b0, KR, 4'b0001);

    // Counter wrap with instr_valid held high: one capture per IDLE cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n       = 1'b1;
    exp_ret     = '0;
    instr       = 32'h0022_1820;
    instr_valid = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("hold%0d.idle", i), {16'h0, obs},
            {16'h0, mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
      check($sformatf("hold%0d.ret", i), {28'h0, retired}, {28'h0, exp_ret});
      push_seq($sformatf("hold%0d", i), KR, 4'b0001, 1'b0);
      drain(3);
      exp_ret = exp_ret + 1'b1;
      @(negedge clk);
    end
    check("wrap.ret", {28'h0, retired}, 32'h0);
    check("wrap.idle", {16'h0, obs},
          {16'h0, mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    instr_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
